// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - MIPS program counter sequencer with branch delay slot.
// Optional misaligned-JR detection is built when PC_ALIGN_CHECK_EN is defined.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        in_delay_slot,
  output logic        fetch_en,
`ifdef PC_ALIGN_CHECK_EN
  output logic        addr_error,
`endif
  output logic        active
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DELAY = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pending_target;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_abs_target;
  logic [31:0] selected_target;
  logic        transfer;
  logic        accept;
  logic        go_halt;

`ifdef PC_ALIGN_CHECK_EN
  logic        misalign_pending;
  logic        jr_misaligned;
  assign jr_misaligned = jump_reg && (reg_target[1:0] != 2'b00);
  assign go_halt       = misalign_pending || (pending_target == HALT_ADDR);
`else
  assign go_halt       = (pending_target == HALT_ADDR);
`endif

  assign pc_plus4        = pc + 32'd4;
  assign link_addr       = pc + 32'd8;
  assign branch_target   = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign jump_abs_target = {pc_plus4[31:28], jump_target, 2'b00};
  assign transfer        = jump_reg || jump || branch_taken;
  assign accept          = instr_valid && !stall;

  always_comb begin
    selected_target = branch_target;
    if (jump_reg)
      selected_target = reg_target;
    else if (jump)
      selected_target = jump_abs_target;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc             <= RESET_VECTOR;
      state          <= RUN;
      pending_target <= 32'd0;
      in_delay_slot  <= 1'b0;
      fetch_en       <= 1'b1;
      active         <= 1'b1;
`ifdef PC_ALIGN_CHECK_EN
      misalign_pending <= 1'b0;
      addr_error       <= 1'b0;
`endif
    end else if (accept) begin
      case (state)
        RUN: begin
          pc <= pc_plus4;
          if (transfer) begin
            pending_target <= selected_target;
            state          <= DELAY;
            in_delay_slot  <= 1'b1;
`ifdef PC_ALIGN_CHECK_EN
            if (jr_misaligned) begin
              misalign_pending <= 1'b1;
              addr_error       <= 1'b1;
            end
`endif
          end
        end
        DELAY: begin
          // Strobes seen in the delay slot are deliberately dropped.
          in_delay_slot <= 1'b0;
          if (go_halt) begin
            pc       <= HALT_ADDR;
            state    <= HALT;
            fetch_en <= 1'b0;
            active   <= 1'b0;
          end else begin
            pc    <= pending_target;
            state <= RUN;
          end
        end
        default: begin
          // HALT is terminal until reset.
          pc <= HALT_ADDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer.
// Exercises the PC_ALIGN_CHECK_EN build when that macro is defined.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jump_reg;
  logic [31:0] reg_target;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        in_delay_slot;
  logic        fetch_en;
  logic        active;
`ifdef PC_ALIGN_CHECK_EN
  logic        addr_error;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        ds;
    logic        act;
    string       name;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  int          m_state;      // 0 run, 1 delay, 2 halt
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  logic        m_mis;
  logic        m_err;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .instr_valid   (instr_valid),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .jump_reg      (jump_reg),
    .reg_target    (reg_target),
    .pc            (pc),
    .link_addr     (link_addr),
    .in_delay_slot (in_delay_slot),
    .fetch_en      (fetch_en),
`ifdef PC_ALIGN_CHECK_EN
    .addr_error    (addr_error),
`endif
    .active        (active)
  );

  task automatic model_reset();
    m_state = 0;
    m_pc    = 32'hBFC00000;
    m_pend  = 32'd0;
    m_mis   = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic st, input logic bt,
                            input logic [15:0] off, input logic j,
                            input logic [25:0] jt, input logic jr,
                            input logic [31:0] rt);
    logic [31:0] nxt;
    nxt = m_pc + 32'd4;
    if (!(v && !st)) return;
    if (m_state == 0) begin
      if (jr || j || bt) begin
        if (jr) m_pend = rt;
        else if (j) m_pend = {nxt[31:28], jt, 2'b00};
        else m_pend = nxt + (32'($signed(off)) * 32'd4);
`ifdef PC_ALIGN_CHECK_EN
        if (jr && rt[1:0] != 2'b00) begin
          m_mis = 1'b1;
          m_err = 1'b1;
        end
`endif
        m_state = 1;
      end
      m_pc = nxt;
    end else if (m_state == 1) begin
      if (m_mis || m_pend == 32'd0) begin
        m_pc    = 32'd0;
        m_state = 2;
      end else begin
        m_pc    = m_pend;
        m_state = 0;
      end
    end
  endtask

  task automatic drive(input string name, input logic v, input logic st,
                       input logic bt, input logic [15:0] off, input logic j,
                       input logic [25:0] jt, input logic jr, input logic [31:0] rt);
    exp_t e;
    exp_t g;
    instr_valid   = v;
    stall         = st;
    branch_taken  = bt;
    branch_offset = off;
    jump          = j;
    jump_target   = jt;
    jump_reg      = jr;
    reg_target    = rt;
    model_step(v, st, bt, off, j, jt, jr, rt);
    e.pc   = m_pc;
    e.ds   = (m_state == 1);
    e.act  = (m_state != 2);
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    checks++;
    if (pc !== g.pc || in_delay_slot !== g.ds || active !== g.act || fetch_en !== g.act) begin
      errors++;
      $display("FAIL %s: pc=%h ds=%b active=%b fetch_en=%b, expected pc=%h ds=%b active=%b",
               g.name, pc, in_delay_slot, active, fetch_en, g.pc, g.ds, g.act);
    end
  endtask

  task automatic plain(input string name);
    drive(name, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    instr_valid = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_offset = 16'h0;
    jump = 1'b0; jump_target = 26'h0; jump_reg = 1'b0; reg_target = 32'h0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc !== 32'hBFC00000 || active !== 1'b1 || fetch_en !== 1'b1 || in_delay_slot !== 1'b0) begin
      errors++;
      $display("FAIL reset: pc=%h active=%b fetch_en=%b ds=%b, expected BFC00000 1 1 0",
               pc, active, fetch_en, in_delay_slot);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) plain("seq");
    drive("idle_hold", 1'b0, 1'b0, 1'b1, 16'h5, 1'b0, 26'h0, 1'b0, 32'h0);
    drive("not_taken", 1'b1, 1'b0, 1'b0, 16'h7, 1'b0, 26'h0, 1'b0, 32'h0);
  endtask

  task automatic test_branch();
    drive("branch_back", 1'b1, 1'b0, 1'b1, 16'hFFFC, 1'b0, 26'h0, 1'b0, 32'h0);
    plain("branch_redirect");
    for (int i = 0; i < 16 && m_pc != 32'hBFC00020; i++) plain("walk");
  endtask

  task automatic test_jump();
    checks++;
    if (link_addr !== m_pc + 32'd8) begin
      errors++;
      $display("FAIL link_addr: got %h expected %h", link_addr, m_pc + 32'd8);
    end
    drive("jal", 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 26'h0000100, 1'b0, 32'h0);
    drive("jal_slot_strobe_ignored", 1'b1, 1'b0, 1'b1, 16'h0100, 1'b1, 26'h3FFFFFF, 1'b0, 32'h0);
    drive("branch_fwd", 1'b1, 1'b0, 1'b1, 16'h0010, 1'b0, 26'h0, 1'b0, 32'h0);
    plain("branch_fwd_redirect");
  endtask

  task automatic test_stall_delay();
    drive("branch_stall", 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 26'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++)
      drive("stall_hold", 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    drive("invalid_hold", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    plain("redirect_after_stall");
  endtask

  task automatic test_reset_in_delay();
    drive("branch_then_reset", 1'b1, 1'b0, 1'b1, 16'h0040, 1'b0, 26'h0, 1'b0, 32'h0);
    do_reset();
    checks++;
    if (pc !== 32'hBFC00000 || in_delay_slot !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_delay: pc=%h ds=%b, expected BFC00000 0", pc, in_delay_slot);
    end
    plain("no_redirect_after_reset");
  endtask

  task automatic test_wrap();
    drive("jr_top", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'hFFFFFFF8);
    plain("jr_top_slot");
    plain("to_top");
    plain("wrap_not_halt");
    plain("after_wrap");
  endtask

  task automatic test_halt();
    drive("jr_zero", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0);
    plain("halt_entry");
    for (int i = 0; i < 3; i++)
      drive("halt_hold", 1'b1, 1'b0, 1'b1, 16'h0004, 1'b1, 26'h1234, 1'b1, 32'h40);
  endtask

`ifdef PC_ALIGN_CHECK_EN
  task automatic test_align();
    do_reset();
    drive("jr_misaligned", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'hBFC00042);
    checks++;
    if (addr_error !== m_err) begin
      errors++;
      $display("FAIL addr_error: got %b expected %b", addr_error, m_err);
    end
    plain("misaligned_halt");
  endtask
`endif

  initial begin
    reset_n = 1'b1;
    model_reset();
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall_delay();
    test_reset_in_delay();
    test_wrap();
    test_halt();
`ifdef PC_ALIGN_CHECK_EN
    test_align();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
